i8008_bus_ctrl: RTL and testbench

I8008_BUS_CTRL -- requirements
Module: i8008_bus_ctrl

---
 rtl/i8008_bus_ctrl.sv | 164 ++++++++++++++++
 tb/tb_i8008_bus_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i8008_bus_ctrl.sv
// rtl/i8008_bus_ctrl.sv - 8008 core bus cycle decoder driving a memory/I-O request interface
module i8008_bus_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  cpu_dout,
  input  logic [2:0]  cpu_state,
  input  logic        cpu_sync,
  output logic [7:0]  cpu_din,
  output logic        cpu_ready,
  output logic [13:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        io_strobe,
  output logic [4:0]  io_port,
  output logic [7:0]  io_data
);

  localparam logic [2:0] ST_T1  = 3'b010;
  localparam logic [2:0] ST_T1I = 3'b011;
  localparam logic [2:0] ST_T2  = 3'b001;
  localparam logic [2:0] ST_T3  = 3'b100;

  typedef enum logic [2:0] {
    IDLE, GOT_LO, RD_WAIT, RD_DONE, WR_DATA, WR_BUSY, IO_DONE
  } state_t;

  state_t      state;
  logic [7:0]  addr_lo;
  // lo_valid / defer track the next cycle's T1/T2 seen while a posted write drains
  logic        lo_valid;
  logic        defer;
  logic [1:0]  dtype;
  logic [13:0] daddr;

  logic        s_t1, s_t2, s_t3;
  logic        issue;
  logic [1:0]  t2_type;
  logic [13:0] t2_addr;

  // Qualified core state samples and the request about to be launched
  always_comb begin
    s_t1    = cpu_sync && (cpu_state == ST_T1 || cpu_state == ST_T1I);
    s_t2    = cpu_sync && (cpu_state == ST_T2);
    s_t3    = cpu_sync && (cpu_state == ST_T3);
    t2_type = defer ? dtype : cpu_dout[7:6];
    t2_addr = defer ? daddr : {cpu_dout[5:0], addr_lo};
    issue   = (state == GOT_LO && s_t2) ||
              (state == WR_BUSY && mem_ack && (defer || (s_t2 && lo_valid)));
  end

  // Bus cycle FSM with all outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_lo   <= 8'h00;
      lo_valid  <= 1'b0;
      defer     <= 1'b0;
      dtype     <= 2'b00;
      daddr     <= 14'h0000;
      cpu_din   <= 8'h00;
      cpu_ready <= 1'b1;
      mem_addr  <= 14'h0000;
      mem_wdata <= 8'h00;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      io_strobe <= 1'b0;
      io_port   <= 5'h00;
      io_data   <= 8'h00;
    end else begin
      io_strobe <= 1'b0;
      if (issue) begin
        // A T2 (live or deferred behind a write) starts the decoded cycle
        lo_valid <= 1'b0;
        defer    <= 1'b0;
        mem_wr   <= 1'b0;
        case (t2_type)
          2'b00, 2'b01: begin
            mem_addr  <= t2_addr;
            mem_rd    <= 1'b1;
            cpu_ready <= 1'b0;
            state     <= RD_WAIT;
          end
          2'b11: begin
            mem_addr  <= t2_addr;
            cpu_ready <= 1'b1;
            state     <= WR_DATA;
          end
          default: begin
            // I/O: port comes from the T2 byte, operand from the T1 byte
            io_port   <= t2_addr[13:9];
            io_data   <= t2_addr[7:0];
            io_strobe <= 1'b1;
            cpu_din   <= 8'h00;
            cpu_ready <= 1'b1;
            state     <= IO_DONE;
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (s_t1) begin
              addr_lo <= cpu_dout;
              state   <= GOT_LO;
            end
          end
          GOT_LO: begin
            if (s_t1) addr_lo <= cpu_dout;
          end
          RD_WAIT: begin
            if (mem_ack) begin
              cpu_din   <= mem_rdata;
              mem_rd    <= 1'b0;
              cpu_ready <= 1'b1;
              state     <= RD_DONE;
            end
          end
          RD_DONE, IO_DONE: begin
            if (s_t3) state <= IDLE;
          end
          WR_DATA: begin
            if (s_t3) begin
              mem_wdata <= cpu_dout;
              mem_wr    <= 1'b1;
              lo_valid  <= 1'b0;
              defer     <= 1'b0;
              state     <= WR_BUSY;
            end
          end
          WR_BUSY: begin
            if (mem_ack) begin
              mem_wr   <= 1'b0;
              lo_valid <= 1'b0;
              if (s_t1) begin
                addr_lo <= cpu_dout;
                state   <= GOT_LO;
              end else if (lo_valid) begin
                state <= GOT_LO;
              end else begin
                state <= IDLE;
              end
            end else begin
              if (s_t1) begin
                addr_lo  <= cpu_dout;
                lo_valid <= 1'b1;
              end
              // New T2 while the write drains: stall the core and remember it
              if (s_t2 && lo_valid && !defer) begin
                defer     <= 1'b1;
                dtype     <= cpu_dout[7:6];
                daddr     <= {cpu_dout[5:0], addr_lo};
                cpu_ready <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i8008_bus_ctrl.sv
// tb/tb_i8008_bus_ctrl.sv - directed-vector bench for i8008_bus_ctrl
module tb_i8008_bus_ctrl;

  localparam logic [2:0] T1 = 3'b010;
  localparam logic [2:0] T2 = 3'b001;
  localparam logic [2:0] T3 = 3'b100;
  localparam logic [2:0] WT = 3'b000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  cpu_dout;
  logic [2:0]  cpu_state;
  logic        cpu_sync;
  logic [7:0]  cpu_din;
  logic        cpu_ready;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        io_strobe;
  logic [4:0]  io_port;
  logic [7:0]  io_data;

  int vectors = 0;
  int miscompares = 0;

  i8008_bus_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_dout(cpu_dout), .cpu_state(cpu_state), .cpu_sync(cpu_sync),
    .cpu_din(cpu_din), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_strobe(io_strobe), .io_port(io_port), .io_data(io_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one edge worth of inputs, then settle just past the rising edge
  task automatic step(input logic [2:0] st, input logic [7:0] d, input logic s,
                      input logic ack, input logic [7:0] rd);
    cpu_state = st; cpu_dout = d; cpu_sync = s; mem_ack = ack; mem_rdata = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_step();
    step(WT, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".din"},   cpu_din,   8'h00);
    chk({tag, ".ready"}, cpu_ready, 1'b1);
    chk({tag, ".addr"},  mem_addr,  14'h0000);
    chk({tag, ".wdata"}, mem_wdata, 8'h00);
    chk({tag, ".rd"},    mem_rd,    1'b0);
    chk({tag, ".wr"},    mem_wr,    1'b0);
    chk({tag, ".iostb"}, io_strobe, 1'b0);
    chk({tag, ".port"},  io_port,   5'h00);
    chk({tag, ".iodat"}, io_data,   8'h00);
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_state = WT; cpu_dout = 8'h00; cpu_sync = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    #6;
    chk_reset_state("reset");
    #1 reset_n = 1'b1;

    // Fetch from 14'h1234, ack three cycles after the request
    step(T1, 8'h34, 1'b1, 1'b0, 8'h00);
    step(T2, 8'h12, 1'b1, 1'b0, 8'h00);
    chk("fetch.addr", mem_addr, 14'h1234);
    chk("fetch.rd", mem_rd, 1'b1);
    chk("fetch.ready0", cpu_ready, 1'b0);
    idle_step();
    idle_step();
    chk("fetch.rd_hold", mem_rd, 1'b1);
    chk("fetch.ready_hold", cpu_ready, 1'b0);
    step(WT, 8'h00, 1'b0, 1'b1, 8'hA5);
    chk("fetch.rd_drop", mem_rd, 1'b0);
    chk("fetch.ready1", cpu_ready, 1'b1);
    step(T3, 8'hEE, 1'b1, 1'b0, 8'h00);
    chk("fetch.din", cpu_din, 8'hA5);
    idle_step();
    chk("fetch.din_keep", cpu_din, 8'hA5);

    // Posted write to 14'h3F00
    step(T1, 8'h00, 1'b1, 1'b0, 8'h00);
    step(T2, 8'hFF, 1'b1, 1'b0, 8'h00);
    chk("wr.addr", mem_addr, 14'h3F00);
    chk("wr.ready_t2", cpu_ready, 1'b1);
    chk("wr.wr_early", mem_wr, 1'b0);
    step(T3, 8'h5C, 1'b1, 1'b0, 8'h00);
    chk("wr.wdata", mem_wdata, 8'h5C);
    chk("wr.wr", mem_wr, 1'b1);
    chk("wr.ready_t3", cpu_ready, 1'b1);
    idle_step();
    chk("wr.wr_hold", mem_wr, 1'b1);
    chk("wr.rd", mem_rd, 1'b0);
    step(WT, 8'h00, 1'b0, 1'b1, 8'h00);
    chk("wr.wr_drop", mem_wr, 1'b0);
    chk("wr.ready_end", cpu_ready, 1'b1);

    // Write with slow ack, then a PCR to 14'h0010 deferred behind it
    step(T1, 8'h00, 1'b1, 1'b0, 8'h00);
    step(T2, 8'hFF, 1'b1, 1'b0, 8'h00);
    step(T3, 8'hAA, 1'b1, 1'b0, 8'h00);
    step(T1, 8'h10, 1'b1, 1'b0, 8'h00);
    chk("b2b.ready_t1", cpu_ready, 1'b1);
    step(T2, 8'h40, 1'b1, 1'b0, 8'h00);
    chk("b2b.ready_t2", cpu_ready, 1'b0);
    chk("b2b.rd_held", mem_rd, 1'b0);
    chk("b2b.addr_kept", mem_addr, 14'h3F00);
    for (int i = 0; i < 7; i++) begin
      idle_step();
      chk("b2b.rd_wait", mem_rd, 1'b0);
    end
    chk("b2b.wr_wait", mem_wr, 1'b1);
    step(WT, 8'h00, 1'b0, 1'b1, 8'h00);
    chk("b2b.wr_drop", mem_wr, 1'b0);
    chk("b2b.rd_go", mem_rd, 1'b1);
    chk("b2b.addr", mem_addr, 14'h0010);
    chk("b2b.ready_rd", cpu_ready, 1'b0);
    step(WT, 8'h00, 1'b0, 1'b1, 8'h3C);
    chk("b2b.ready1", cpu_ready, 1'b1);
    chk("b2b.rd_drop", mem_rd, 1'b0);
    step(T3, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("b2b.din", cpu_din, 8'h3C);

    // I/O cycle: port 5, operand 8'h77
    step(T1, 8'h77, 1'b1, 1'b0, 8'h00);
    step(T2, 8'h8A, 1'b1, 1'b0, 8'h00);
    chk("io.strobe", io_strobe, 1'b1);
    chk("io.port", io_port, 5'h05);
    chk("io.data", io_data, 8'h77);
    chk("io.din", cpu_din, 8'h00);
    chk("io.rd", mem_rd, 1'b0);
    chk("io.wr", mem_wr, 1'b0);
    idle_step();
    chk("io.strobe_off", io_strobe, 1'b0);
    step(T3, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("io.din_t3", cpu_din, 8'h00);
    chk("io.rd_t3", mem_rd, 1'b0);

    // Reset while a read is outstanding, then a stray ack
    step(T1, 8'h34, 1'b1, 1'b0, 8'h00);
    step(T2, 8'h12, 1'b1, 1'b0, 8'h00);
    chk("rst.rd_before", mem_rd, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_state("rst.async");
    reset_n = 1'b1;
    step(WT, 8'h00, 1'b0, 1'b1, 8'hFF);
    chk_reset_state("rst.stray");

    // Unqualified T1/T2, then lone T2 and T3 while idle
    step(T1, 8'h34, 1'b0, 1'b0, 8'h00);
    step(T2, 8'h12, 1'b0, 1'b0, 8'h00);
    chk("nosync.rd", mem_rd, 1'b0);
    chk("nosync.addr", mem_addr, 14'h0000);
    chk("nosync.ready", cpu_ready, 1'b1);
    step(T2, 8'h12, 1'b1, 1'b0, 8'h00);
    chk("lone_t2.rd", mem_rd, 1'b0);
    chk("lone_t2.addr", mem_addr, 14'h0000);
    step(T3, 8'h99, 1'b1, 1'b0, 8'h00);
    chk("lone_t3.din", cpu_din, 8'h00);
    chk("lone_t3.wr", mem_wr, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
